fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
// Sequences an in-place radix-2 DIF FFT over a sample RAM and one shared butterfly/dsp_mult datapath.
// For every stage it issues butterfly operand read-address pairs and twiddle indices.
// It tracks in-flight operations through the fixed-latency datapath and issues the matching write-backs.
// It drains between stages to avoid read-after-write hazards, then pulses done when all stages are complete.
// PARAMETERS
// N_POINTS     8                    FFT size; power of two, >= 4
// ADDR_W       $clog2(N_POINTS)     sample RAM address width
// MULT_LATENCY 3                    dsp_mult pipeline depth in cycles (>= 1)
// (derived) STAGES = ADDR_W; PIPE = 1 + MULT_LATENCY (1 cycle for RAM read + multiplier latency)
// PORTS
// clk_i        in   1               clock; all logic on rising edge
// rst_i        in   1               synchronous, active-low reset
// start_i      in   1               start a transform; honoured only in IDLE
// stall_i      in   1               hold issue this cycle (in-flight ops continue)
// busy_o       out  1               high from the cycle after start is accepted until done
// done_o       out  1               1-cycle pulse when the last write-back has completed
// stage_o      out  ADDR_W          current stage index, 0..STAGES-1
// rd_en_o      out  1               read operand pair this cycle
// rd_addr_a_o  out  ADDR_W          address of upper operand
// rd_addr_b_o  out  ADDR_W          address of lower operand
// tw_idx_o     out  ADDR_W-1        twiddle index into w[] for this pair; valid with rd_en_o
// bf_valid_o   out  1               butterfly input valid; equals rd_en_o delayed 1 cycle
// wr_en_o      out  1               write results back; equals rd_en_o delayed PIPE cycles
// wr_addr_a_o  out  ADDR_W          rd_addr_a_o delayed PIPE cycles (sum result)
// wr_addr_b_o  out  ADDR_W          rd_addr_b_o delayed PIPE cycles (twiddled difference)
// BEHAVIOUR
// - Reset (rst_i==0 at a clock edge): FSM goes to IDLE.
//   All outputs are 0; in-flight delay lines are cleared, so no wr_en_o occurs after reset.
//   A reset mid-operation abandons the transform and gives no done_o.
// - FSM states: IDLE, ISSUE, DRAIN, DONE.
//   IDLE --start_i--> ISSUE, with stage=0 and k=0.
//   ISSUE --last pair issued--> DRAIN.
//   DRAIN --pipeline empty, stage<STAGES-1--> ISSUE, with stage+1 and k=0.
//   DRAIN --pipeline empty, last stage--> DONE.
//   DONE --> IDLE after 1 cycle.
// - start_i outside IDLE is ignored; no queuing.
// - busy_o is 1 in ISSUE and DRAIN. done_o is 1 only in DONE.
// - Address generation for stage s and butterfly k (0..N/2-1):
//   span = N>>(s+1); j = k mod span; g = k / span.
//   rd_addr_a_o = g*2*span + j; rd_addr_b_o = rd_addr_a_o + span.
//   tw_idx_o = j<<s, truncated to ADDR_W-1 bits.
// - ISSUE, stall_i==0: rd_en_o=1 and k increments. ISSUE, stall_i==1: rd_en_o=0 and k holds.
//   Addresses are don't-care while rd_en_o=0.
// - Delay lines: bf_valid_o, wr_en_o and write addresses are shift registers of fixed depth, unaffected by stall_i.
// - Stage boundary: the first rd_en_o of stage s+1 occurs exactly 1 cycle after the last wr_en_o of stage s.
// - DONE is entered the cycle after the final wr_en_o.
// - Timing, no stalls: start_i sampled at edge 0; first rd_en_o in cycle 1.
//   Each stage lasts N/2+PIPE cycles; done_o is in cycle 1+STAGES*(N/2+PIPE).
// - stage_o updates on entry to ISSUE and holds through DRAIN.
// - Simultaneous start_i and rst_i==0: reset wins.
// TESTING
// 1 Defaults, start pulse, no stall. Required:
//   - rd pairs stage0 (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3;
//   - stage1 (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2;
//   - stage2 (0,1)(2,3)(4,5)(6,7), tw all 0;
//   - done_o in cycle 25 only.
// 2 Write-back alignment: every wr_en_o is exactly 4 cycles after its rd_en_o, with identical addresses.
//   bf_valid_o lags rd_en_o by 1 cycle. 12 writes total.
// 3 stall_i high for cycles 2-4 in stage 0.
//   Required: rd_en_o low on those cycles, pair sequence unchanged, done_o shifted to cycle 28.
// 4 start_i re-asserted while busy_o=1 -> ignored; exactly one done_o; busy_o falls the cycle done_o rises.
// 5 rst_i=0 in cycle 10 (mid stage 1).
//   Required: next cycle all outputs 0, no further wr_en_o, no done_o.
//   A new start_i then completes normally in 24 cycles.
// 6 N_POINTS=16, MULT_LATENCY=1.
//   Required: 4 stages of 8 pairs; stage0 tw 0..7; done_o in cycle 1+4*(8+2)=41.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIF FFT sharing one butterfly datapath.
// Issues operand pairs and twiddle indices per stage, then drains the pipeline between stages.
module fft_stage_sequencer #(
    parameter int N_POINTS     = 8,
    parameter int ADDR_W       = $clog2(N_POINTS),
    parameter int MULT_LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] stage_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_a_o,
    output logic [ADDR_W-1:0] rd_addr_b_o,
    output logic [ADDR_W-2:0] tw_idx_o,
    output logic              bf_valid_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_a_o,
    output logic [ADDR_W-1:0] wr_addr_b_o
);

    localparam int STAGES = ADDR_W;
    localparam int PIPE   = 1 + MULT_LATENCY;
    localparam int KW     = ADDR_W - 1;

    localparam logic [KW-1:0]     K_LAST  = KW'(N_POINTS / 2 - 1);
    localparam logic [KW-1:0]     K_ONE   = KW'(1);
    localparam logic [ADDR_W-1:0] ST_LAST = ADDR_W'(STAGES - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] stage_q, stage_d;
    logic [KW-1:0]     k_q, k_d;
    logic [PIPE-1:0]   vld_q, vld_d;
    logic [ADDR_W-1:0] addr_a_q [PIPE];
    logic [ADDR_W-1:0] addr_b_q [PIPE];

    logic              rd_en;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] shamt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] k_ext;
    logic [ADDR_W-1:0] j_w;
    logic [ADDR_W-1:0] g_w;
    logic [ADDR_W-1:0] a_w;
    logic [ADDR_W-1:0] b_w;
    logic [KW-1:0]     tw_w;

    // Butterfly addressing: span = N>>(s+1) = 1<<(STAGES-1-s)
    always_comb begin
        shamt = ST_LAST - stage_q;
        span  = ONE_A << shamt;
        k_ext = {1'b0, k_q};
        j_w   = k_ext & (span - ONE_A);
        g_w   = k_ext >> shamt;
        a_w   = ((g_w << 1) << shamt) | j_w;
        b_w   = a_w | span;
        tw_w  = KW'(j_w << stage_q);
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (!stall_i) begin
                    rd_en = 1'b1;
                    k_d   = k_q + K_ONE;
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Only the write-back leaving this cycle may remain in flight.
                if (vld_q[PIPE-2:0] == '0) begin
                    if (stage_q == ST_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + ONE_A;
                        k_d     = '0;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vld_d = {vld_q[PIPE-2:0], rd_en};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            vld_q   <= vld_d;
        end
    end

    // Address delay lines carry no reset; their outputs are qualified by wr_en_o.
    always_ff @(posedge clk_i) begin
        addr_a_q[0] <= rd_addr_a_o;
        addr_b_q[0] <= rd_addr_b_o;
        for (int i = 1; i < PIPE; i++) begin
            addr_a_q[i] <= addr_a_q[i-1];
            addr_b_q[i] <= addr_b_q[i-1];
        end
    end

    assign busy_o      = busy;
    assign done_o      = done;
    assign stage_o     = stage_q;
    assign rd_en_o     = rd_en;
    assign rd_addr_a_o = rd_en ? a_w : '0;
    assign rd_addr_b_o = rd_en ? b_w : '0;
    assign tw_idx_o    = rd_en ? tw_w : '0;
    assign bf_valid_o  = vld_q[0];
    assign wr_en_o     = vld_q[PIPE-1];
    assign wr_addr_a_o = vld_q[PIPE-1] ? addr_a_q[PIPE-1] : '0;
    assign wr_addr_b_o = vld_q[PIPE-1] ? addr_b_q[PIPE-1] : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: an 8-point/latency-3 instance and a 16-point/latency-1 instance.
module tb_fft_stage_sequencer;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_i = 1'b0;
    logic start8 = 1'b0, stall8 = 1'b0, start16 = 1'b0, stall16 = 1'b0;

    logic       busy8, done8, rd8, bf8, wr8;
    logic [2:0] stage8, ra8, rb8, wa8, wb8;
    logic [1:0] tw8;

    logic       busy16, done16, rd16, bf16, wr16;
    logic [3:0] stage16, ra16, rb16, wa16, wb16;
    logic [2:0] tw16;

    fft_stage_sequencer #(.N_POINTS(8), .MULT_LATENCY(3)) dut8 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start8), .stall_i(stall8),
        .busy_o(busy8), .done_o(done8), .stage_o(stage8), .rd_en_o(rd8),
        .rd_addr_a_o(ra8), .rd_addr_b_o(rb8), .tw_idx_o(tw8), .bf_valid_o(bf8),
        .wr_en_o(wr8), .wr_addr_a_o(wa8), .wr_addr_b_o(wb8)
    );

    fft_stage_sequencer #(.N_POINTS(16), .MULT_LATENCY(1)) dut16 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start16), .stall_i(stall16),
        .busy_o(busy16), .done_o(done16), .stage_o(stage16), .rd_en_o(rd16),
        .rd_addr_a_o(ra16), .rd_addr_b_o(rb16), .tw_idx_o(tw16), .bf_valid_o(bf16),
        .wr_en_o(wr16), .wr_addr_a_o(wa16), .wr_addr_b_o(wb16)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sel   = 8;
    int rst_cyc = -1;
    bit force_rst = 1'b1;
    int s1 = -1, s2 = -1, s3 = -1;
    int stall_lo = -1, stall_hi = -1;

    int rd_a[$], rd_b[$], rd_tw[$], rd_st[$], rd_c[$];
    int wr_a[$], wr_b[$], wr_c[$], bf_c[$], dn_c[$];
    int busy_log [128];

    int exp_a8[12]  = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int exp_b8[12]  = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int exp_tw8[12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};

    int exp_a16[32]  = '{0,1,2,3,4,5,6,7, 0,1,2,3,8,9,10,11,
                         0,1,4,5,8,9,12,13, 0,2,4,6,8,10,12,14};
    int exp_tw16[32] = '{0,1,2,3,4,5,6,7, 0,2,4,6,0,2,4,6,
                         0,4,0,4,0,4,0,4, 0,0,0,0,0,0,0,0};

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_a.delete(); rd_b.delete(); rd_tw.delete(); rd_st.delete(); rd_c.delete();
        wr_a.delete(); wr_b.delete(); wr_c.delete(); bf_c.delete(); dn_c.delete();
        for (int i = 0; i < 128; i++) busy_log[i] = -1;
    endtask

    task automatic sample();
        int r, a, b, tw, st, bfv, w, wa, wb, bsy, dn;
        if (sel == 8) begin
            r = int'(rd8); a = int'(ra8); b = int'(rb8); tw = int'(tw8); st = int'(stage8);
            bfv = int'(bf8); w = int'(wr8); wa = int'(wa8); wb = int'(wb8);
            bsy = int'(busy8); dn = int'(done8);
        end else begin
            r = int'(rd16); a = int'(ra16); b = int'(rb16); tw = int'(tw16); st = int'(stage16);
            bfv = int'(bf16); w = int'(wr16); wa = int'(wa16); wb = int'(wb16);
            bsy = int'(busy16); dn = int'(done16);
        end
        if (cyc >= 0 && cyc < 128) busy_log[cyc] = bsy;
        if (r == 1) begin
            rd_a.push_back(a); rd_b.push_back(b); rd_tw.push_back(tw);
            rd_st.push_back(st); rd_c.push_back(cyc);
        end
        if (bfv == 1) bf_c.push_back(cyc);
        if (w == 1) begin
            wr_a.push_back(wa); wr_b.push_back(wb); wr_c.push_back(cyc);
        end
        if (dn == 1) dn_c.push_back(cyc);
    endtask

    task automatic tick();
        logic st, stl;
        @(posedge clk_i);
        #1;
        cyc++;
        st  = (cyc == s1) || (cyc == s2) || (cyc == s3);
        stl = (cyc >= stall_lo) && (cyc <= stall_hi);
        start8  = (sel == 8)  ? st  : 1'b0;
        stall8  = (sel == 8)  ? stl : 1'b0;
        start16 = (sel == 16) ? st  : 1'b0;
        stall16 = (sel == 16) ? stl : 1'b0;
        rst_i   = !(force_rst || (cyc == rst_cyc));
        #1;
        sample();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Start pulse sampled at edge 0; cycle 1 follows that edge.
    task automatic kick(input int which);
        clear_logs();
        sel = which;
        cyc = 0;
        if (which == 8) start8 = 1'b1; else start16 = 1'b1;
    endtask

    task automatic chk_zero8(input string t);
        chk({t, "_busy"}, int'(busy8), 0);
        chk({t, "_done"}, int'(done8), 0);
        chk({t, "_stage"}, int'(stage8), 0);
        chk({t, "_rd_en"}, int'(rd8), 0);
        chk({t, "_rd_a"}, int'(ra8), 0);
        chk({t, "_rd_b"}, int'(rb8), 0);
        chk({t, "_tw"}, int'(tw8), 0);
        chk({t, "_bf"}, int'(bf8), 0);
        chk({t, "_wr_en"}, int'(wr8), 0);
        chk({t, "_wr_a"}, int'(wa8), 0);
        chk({t, "_wr_b"}, int'(wb8), 0);
    endtask

    // Expected read cycle of pair i: 1 + stage*8 + k, plus the stall gap for every pair after the first.
    task automatic check_n8(input string t, input int done_exp, input int gap);
        int rc;
        chk({t, "_rd_cnt"}, rd_a.size(), 12);
        chk({t, "_wr_cnt"}, wr_a.size(), 12);
        chk({t, "_bf_cnt"}, bf_c.size(), 12);
        chk({t, "_done_cnt"}, dn_c.size(), 1);
        chk({t, "_done_cyc"}, (dn_c.size() > 0) ? dn_c[0] : -1, done_exp);
        chk({t, "_busy_at_done"}, busy_log[done_exp], 0);
        chk({t, "_busy_before_done"}, busy_log[done_exp-1], 1);
        for (int i = 0; i < 12; i++) begin
            rc = 1 + (i / 4) * 8 + (i % 4) + ((i >= 1) ? gap : 0);
            if (i < rd_a.size()) begin
                chk($sformatf("%s_rd_a%0d", t, i), rd_a[i], exp_a8[i]);
                chk($sformatf("%s_rd_b%0d", t, i), rd_b[i], exp_b8[i]);
                chk($sformatf("%s_tw%0d", t, i), rd_tw[i], exp_tw8[i]);
                chk($sformatf("%s_stage%0d", t, i), rd_st[i], i / 4);
                chk($sformatf("%s_rd_cyc%0d", t, i), rd_c[i], rc);
            end
            if (i < wr_a.size()) begin
                chk($sformatf("%s_wr_a%0d", t, i), wr_a[i], exp_a8[i]);
                chk($sformatf("%s_wr_b%0d", t, i), wr_b[i], exp_b8[i]);
                chk($sformatf("%s_wr_cyc%0d", t, i), wr_c[i], rc + 4);
            end
            if (i < bf_c.size()) begin
                chk($sformatf("%s_bf_cyc%0d", t, i), bf_c[i], rc + 1);
            end
        end
    endtask

    initial begin
        int rc;
        clear_logs();

        // Reset state, with start asserted during reset: reset must win.
        sel = 8;
        start8 = 1'b1;
        start16 = 1'b1;
        tick();
        run(2);
        chk_zero8("rst");
        chk("rst_busy16", int'(busy16), 0);
        chk("rst_wr16", int'(wr16), 0);
        chk("rst_done16", int'(done16), 0);
        force_rst = 1'b0;
        run(2);
        chk("idle_busy8", int'(busy8), 0);

        // 1/2: nominal transform and write-back alignment.
        kick(8);
        run(32);
        check_n8("t1", 25, 0);

        // 3: stall on cycles 2-4 of stage 0.
        kick(8);
        stall_lo = 2; stall_hi = 4;
        run(34);
        stall_lo = -1; stall_hi = -1;
        check_n8("t3", 28, 3);

        // 4: start re-asserted while busy and in the DONE cycle.
        kick(8);
        s1 = 5; s2 = 20; s3 = 25;
        run(32);
        s1 = -1; s2 = -1; s3 = -1;
        check_n8("t4", 25, 0);
        chk("t4_busy_26", busy_log[26], 0);
        chk("t4_busy_27", busy_log[27], 0);

        // 5: reset in cycle 10, then a fresh start.
        kick(8);
        rst_cyc = 10;
        run(11);
        chk_zero8("t5_after_rst");
        run(20);
        rst_cyc = -1;
        chk("t5_wr_cnt", wr_a.size(), 4);
        chk("t5_done_cnt", dn_c.size(), 0);
        chk("t5_last_wr_cyc", (wr_c.size() > 0) ? wr_c[wr_c.size()-1] : -1, 8);
        kick(8);
        run(30);
        chk("t5_re_done_cnt", dn_c.size(), 1);
        chk("t5_re_done_cyc", (dn_c.size() > 0) ? dn_c[0] : -1, 25);
        chk("t5_re_rd_cnt", rd_a.size(), 12);
        chk("t5_re_wr_cnt", wr_a.size(), 12);

        // 6: 16 points, multiplier latency 1 (PIPE = 2, stage length 10).
        kick(16);
        run(48);
        chk("t6_rd_cnt", rd_a.size(), 32);
        chk("t6_wr_cnt", wr_a.size(), 32);
        chk("t6_done_cnt", dn_c.size(), 1);
        chk("t6_done_cyc", (dn_c.size() > 0) ? dn_c[0] : -1, 41);
        for (int i = 0; i < 32; i++) begin
            rc = 1 + (i / 8) * 10 + (i % 8);
            if (i < rd_a.size()) begin
                chk($sformatf("t6_rd_a%0d", i), rd_a[i], exp_a16[i]);
                chk($sformatf("t6_rd_b%0d", i), rd_b[i], exp_a16[i] + (8 >> (i / 8)));
                chk($sformatf("t6_tw%0d", i), rd_tw[i], exp_tw16[i]);
                chk($sformatf("t6_rd_cyc%0d", i), rd_c[i], rc);
            end
            if (i < wr_a.size()) begin
                chk($sformatf("t6_wr_a%0d", i), wr_a[i], exp_a16[i]);
                chk($sformatf("t6_wr_cyc%0d", i), wr_c[i], rc + 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
